// File: rtl/ft232h_tx_arbiter.sv
// ft232h_tx_arbiter
//   Shares the host-bound (read) side of ft232h_bridge among NUM_CH byte-stream
//   sources. A round-robin scheduler grants one source at a time and frames
//   each burst with a header byte {ch_id[1:0], len[5:0]}. Toward the bridge it
//   looks like a first-word-fall-through FIFO read port.
//
//   Optional build macro: FT_TX_CHECKSUM_EN
//     defined   -> each burst is followed by a trailer byte holding the XOR of
//                  its payload bytes.
//     undefined -> frame is header + len payload bytes only.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   ch_en_i      per-source enable (a disabled source is never granted)
//   ch_level_i   per-source occupancy, source i at [i*LVL_W +: LVL_W]
//   ch_empty_i   per-source FIFO empty
//   ch_dout_i    per-source FWFT head byte, source i at [i*8 +: 8]
//   ch_rd_en_o   per-source pop strobe
//   empty        to bridge: no byte available
//   rd_en        from bridge: pop current dout
//   dout         to bridge: current byte
//   busy_o       burst in progress
//   cur_ch_o     granted source id (meaningful while busy_o)
module ft232h_tx_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int LVL_W     = 8,
   parameter int MAX_BURST = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       ch_en_i,
   input  logic [NUM_CH*LVL_W-1:0] ch_level_i,
   input  logic [NUM_CH-1:0]       ch_empty_i,
   input  logic [NUM_CH*8-1:0]     ch_dout_i,
   output logic [NUM_CH-1:0]       ch_rd_en_o,
   output logic                    empty,
   input  logic                    rd_en,
   output logic [7:0]              dout,
   output logic                    busy_o,
   output logic [1:0]              cur_ch_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2
`ifdef FT_TX_CHECKSUM_EN
      , S_TRL = 2'd3
`endif
   } state_t;

   state_t                       r_state;
   logic [1:0]                   r_rr_ptr;
   logic [1:0]                   r_grant;
   logic [5:0]                   r_rem;
   logic [7:0]                   r_hdr;
   logic [NUM_CH-1:0][LVL_W-1:0] r_level;
`ifdef FT_TX_CHECKSUM_EN
   logic [7:0]                   r_xor;
`endif

   logic             w_cur_empty;
   logic [7:0]       w_cur_dout;
   logic             w_pop;
   logic             w_found;
   logic [1:0]       w_sel;
   logic [LVL_W-1:0] w_sel_lvl;
   logic [5:0]       w_len;
   logic [1:0]       w_rr_next;

   // Head-of-line view of the granted source
   always_comb begin
      w_cur_empty = 1'b1;
      w_cur_dout  = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant == 2'(i)) begin
            w_cur_empty = ch_empty_i[i];
            w_cur_dout  = ch_dout_i[i*8 +: 8];
         end
      end
   end

   assign w_pop = (r_state == S_DATA) && rd_en && !w_cur_empty;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         ch_rd_en_o[i] = w_pop && (r_grant == 2'(i));
   end

   // Round-robin search starting at r_rr_ptr over the sampled levels.
   always_comb begin
      w_found   = 1'b0;
      w_sel     = 2'd0;
      w_sel_lvl = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && (((int'(r_rr_ptr) + k) % NUM_CH) == i) &&
                ch_en_i[i] && (r_level[i] != '0)) begin
               w_found   = 1'b1;
               w_sel     = 2'(i);
               w_sel_lvl = r_level[i];
            end
         end
      end
   end

   // Compare at full level width before truncating to the 6-bit length field
   assign w_len     = (32'(w_sel_lvl) > 32'(MAX_BURST)) ? 6'(MAX_BURST) : 6'(w_sel_lvl);
   assign w_rr_next = (r_grant == 2'(NUM_CH-1)) ? 2'd0 : r_grant + 2'd1;

   // Level sample register. The pop made this cycle is subtracted so the IDLE
   // cycle right after a burst sees the post-pop occupancy rather than a stale
   // count that still includes the final byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            r_level[i] <= ch_level_i[i*LVL_W +: LVL_W] - LVL_W'(ch_rd_en_o[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 2'd0;
         r_grant  <= 2'd0;
         r_rem    <= 6'd0;
         r_hdr    <= 8'h00;
`ifdef FT_TX_CHECKSUM_EN
         r_xor    <= 8'h00;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_sel;
                  r_hdr   <= {w_sel, w_len};
                  r_state <= S_HDR;
`ifdef FT_TX_CHECKSUM_EN
                  r_xor   <= 8'h00;
`endif
               end
            end
            S_HDR: begin
               if (rd_en) begin
                  r_rem   <= r_hdr[5:0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_pop) begin
                  r_rem <= r_rem - 6'd1;
`ifdef FT_TX_CHECKSUM_EN
                  r_xor <= r_xor ^ w_cur_dout;
`endif
                  if (r_rem == 6'd1) begin
                     r_rr_ptr <= w_rr_next;
`ifdef FT_TX_CHECKSUM_EN
                     r_state  <= S_TRL;
`else
                     r_state  <= S_IDLE;
`endif
                  end
               end
            end
`ifdef FT_TX_CHECKSUM_EN
            S_TRL: begin
               if (rd_en) r_state <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Bridge-facing port: decoded from state, so reset clears it immediately
   always_comb begin
      empty = 1'b1;
      dout  = 8'h00;
      case (r_state)
         S_HDR: begin
            empty = 1'b0;
            dout  = r_hdr;
         end
         S_DATA: begin
            empty = w_cur_empty;
            dout  = w_cur_dout;
         end
`ifdef FT_TX_CHECKSUM_EN
         S_TRL: begin
            empty = 1'b0;
            dout  = r_xor;
         end
`endif
         default: begin
            empty = 1'b1;
            dout  = 8'h00;
         end
      endcase
   end

   assign busy_o   = (r_state != S_IDLE);
   assign cur_ch_o = r_grant;

endmodule

// File: tb/tb_ft232h_tx_arbiter.sv
// Scoreboard bench for ft232h_tx_arbiter: source FIFOs are modelled as queues,
// expected bridge bytes are queued as stimulus is issued, and a negedge
// monitor pops and compares every byte the bridge accepts.
module tb_ft232h_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  ch_en_i = 4'hF;
   logic [31:0] ch_level_i = '0;
   logic [3:0]  ch_empty_i = 4'hF;
   logic [31:0] ch_dout_i = '0;
   logic [3:0]  ch_rd_en_o;
   logic        empty;
   logic        rd_en = 1'b0;
   logic [7:0]  dout;
   logic        busy_o;
   logic [1:0]  cur_ch_o;

   ft232h_tx_arbiter #(.NUM_CH(4), .LVL_W(8), .MAX_BURST(32)) dut (
      .clk(clk), .rst_n(rst_n), .ch_en_i(ch_en_i), .ch_level_i(ch_level_i),
      .ch_empty_i(ch_empty_i), .ch_dout_i(ch_dout_i), .ch_rd_en_o(ch_rd_en_o),
      .empty(empty), .rd_en(rd_en), .dout(dout), .busy_o(busy_o), .cur_ch_o(cur_ch_o)
   );

   always #5 clk = ~clk;

   logic [7:0] srcq[4][$];
   logic [7:0] expq[$];
   logic [7:0] mon_exp;
   logic [3:0] pend = 4'h0;
   logic [3:0] hold = 4'h0;
   int         stall_left = 0;
   bit         stall_arm = 1'b0;
   bit         stall_done = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   // Pop strobes are stable at negedge; apply them to the source model after the edge
   always @(negedge clk) pend = ch_rd_en_o;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++)
         if (pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (stall_left > 0) begin
         stall_left = stall_left - 1;
         if (stall_left == 0) hold[0] = 1'b0;
      end else if (stall_arm && !stall_done && srcq[0].size() == 2) begin
         hold[0]    = 1'b1;
         stall_left = 10;
         stall_done = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         ch_level_i[i*8 +: 8] = 8'(srcq[i].size());
         ch_empty_i[i]        = (srcq[i].size() == 0) || hold[i];
         ch_dout_i[i*8 +: 8]  = (srcq[i].size() != 0 && !hold[i]) ? srcq[i][0] : 8'hEE;
      end
   end

   // Monitor: every accepted byte is checked against the scoreboard
   always @(negedge clk) begin
      if (rst_n && rd_en && !empty) begin
         n_cmp = n_cmp + 1;
         if (expq.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL byte_stream: got %02h, required none (queue empty)", dout);
         end else begin
            mon_exp = expq.pop_front();
            if (dout !== mon_exp) begin
               n_bad = n_bad + 1;
               $display("FAIL byte_stream: got %02h, required %02h", dout, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp = n_cmp + 1;
      if (act !== req) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic feed(input int ch, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) srcq[ch].push_back(base + 8'(k));
   endtask

   task automatic expect_burst(input logic [7:0] hdr, input logic [7:0] base);
`ifdef FT_TX_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
`endif
      expq.push_back(hdr);
      for (int k = 0; k < int'(hdr[5:0]); k++) begin
         expq.push_back(base + 8'(k));
`ifdef FT_TX_CHECKSUM_EN
         x = x ^ (base + 8'(k));
`endif
      end
`ifdef FT_TX_CHECKSUM_EN
      expq.push_back(x);
`endif
   endtask

   task automatic drain(input string nm);
      int cyc;
      cyc = 0;
      while ((expq.size() != 0 || busy_o) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk(nm, {31'd0, (expq.size() == 0 && !busy_o)}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_dout", {24'd0, dout}, 32'h00);
      chk("rst_rd_en", {28'd0, ch_rd_en_o}, 32'h0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_cur_ch", {30'd0, cur_ch_o}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // 1: single source, header latency t+2
      feed(0, 3, 8'hA1);
      expect_burst(8'h03, 8'hA1);
      @(posedge clk); #2;
      @(negedge clk);
      chk("t1_t0_empty", {31'd0, empty}, 32'd1);
      @(negedge clk);
      chk("t1_t1_empty", {31'd0, empty}, 32'd1);
      chk("t1_t1_busy", {31'd0, busy_o}, 32'd0);
      #1 rd_en = 1'b1;
      @(negedge clk);
      chk("t1_hdr_empty", {31'd0, empty}, 32'd0);
      chk("t1_hdr_dout", {24'd0, dout}, 32'h03);
      chk("t1_hdr_busy", {31'd0, busy_o}, 32'd1);
      drain("t1_drain");
      chk("t1_idle_empty", {31'd0, empty}, 32'd1);

      // 2: two sources, round robin order
      feed(1, 5, 8'h10);
      feed(3, 2, 8'h30);
      expect_burst(8'h45, 8'h10);
      expect_burst(8'hC2, 8'h30);
      drain("t2_drain");

      // 3: long source split into MAX_BURST chunks
      feed(2, 100, 8'h00);
      expect_burst(8'hA0, 8'h00);
      expect_burst(8'hA0, 8'h20);
      expect_burst(8'hA0, 8'h40);
      expect_burst(8'h84, 8'h60);
      drain("t3_drain");

      // 4: source stalls for 10 cycles after 2 of 4 bytes
      stall_arm = 1'b1;
      feed(0, 4, 8'h50);
      expect_burst(8'h04, 8'h50);
      c = 0;
      while (!hold[0] && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("t4_stall_seen", {31'd0, hold[0]}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         chk("t4_stall", {27'd0, empty, ch_rd_en_o}, 32'h10);
         @(negedge clk);
      end
      drain("t4_drain");

      // 5: reset during DATA with remaining=3
      feed(0, 5, 8'h60);
      expq.push_back(8'h05);
      expq.push_back(8'h60);
      expq.push_back(8'h61);
      c = 0;
      while (srcq[0].size() != 3 && c < 200) begin
         @(posedge clk); #2;
         c++;
      end
      chk("t5_reached", srcq[0].size(), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t5_async_empty", {31'd0, empty}, 32'd1);
      chk("t5_async_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_async_rd_en", {28'd0, ch_rd_en_o}, 32'h0);
      chk("t5_async_cur_ch", {30'd0, cur_ch_o}, 32'd0);
      chk("t5_sb_consumed", expq.size(), 32'd0);
      feed(1, 2, 8'h70);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      expect_burst(8'h03, 8'h62);
      expect_burst(8'h42, 8'h70);
      drain("t5_drain");

      // 6: disabled source is skipped until re-enabled
      ch_en_i = 4'b1101;
      feed(1, 7, 8'h80);
      feed(2, 1, 8'h90);
      expect_burst(8'h81, 8'h90);
      drain("t6_drain");
      repeat (10) @(negedge clk);
      chk("t6_src1_held", srcq[1].size(), 32'd7);
      chk("t6_idle_busy", {31'd0, busy_o}, 32'd0);
      ch_en_i = 4'hF;
      expect_burst(8'h47, 8'h80);
      drain("t6_reenable_drain");
      chk("end_empty", {31'd0, empty}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
